// File: rtl/cva5_types.sv
// Shared CVA5 types used by the writeback path: instruction ids and writeback packets.
package cva5_types;
  localparam int MAX_NUM_UNITS = 8;
  localparam int XLEN          = 32;
  localparam int MAX_IDS       = 16;

  typedef logic [$clog2(MAX_IDS)-1:0] id_t;

  typedef struct packed {
    logic             valid;
    id_t              id;
    logic [XLEN-1:0]  data;
  } wb_packet_t;
endpackage

// File: rtl/multi_port_writeback_if.sv
// Bundle between the execution units and the writeback block: per-unit results in,
// per-unit acks and per-port registered writeback packets out.
interface multi_port_writeback_if
  import cva5_types::*;
#(
  parameter int NUM_WB_UNITS = 5,
  parameter int NUM_WB_PORTS = 2,
  parameter int DATA_WIDTH   = 32
);
  id_t  [NUM_WB_UNITS-1:0]                 unit_id;
  logic [NUM_WB_UNITS-1:0]                 unit_done;
  logic [NUM_WB_UNITS-1:0][DATA_WIDTH-1:0] unit_rd;
  logic [NUM_WB_UNITS-1:0]                 unit_ack;
  wb_packet_t [NUM_WB_PORTS-1:0]           wb_packet;

  modport master (output unit_id, unit_done, unit_rd, input unit_ack, wb_packet);
  modport slave  (input unit_id, unit_done, unit_rd, output unit_ack, wb_packet);
endinterface

// File: rtl/rr_multi_grant.sv
// Picks up to P requesters per cycle, scanning from ptr with wrap; port p gets the
// p-th request found, and last_idx reports the final request granted.
module rr_multi_grant #(
  parameter int N = 5,
  parameter int P = 2,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]          req,
  input  logic [PTR_W-1:0]      ptr,
  output logic [P-1:0][N-1:0]   grant,
  output logic [PTR_W-1:0]      last_idx
);
  always_comb begin
    logic [N-1:0]     taken;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;
    // NOTE: every output and local gets a default before any conditional write, so no latch is inferred.
    grant    = '0;
    last_idx = ptr;
    taken    = '0;
    sum      = '0;
    idx      = '0;
    found    = 1'b0;
    for (int p = 0; p < P; p++) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        // Sum never exceeds 2N-2, so one conditional subtract is a full modulo.
        sum = {1'b0, ptr} + (PTR_W+1)'(k);
        if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
        idx = sum[PTR_W-1:0];
        if (!found && req[idx] && !taken[idx]) begin
          grant[p][idx] = 1'b1;
          taken[idx]    = 1'b1;
          last_idx      = idx;
          found         = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/multi_port_writeback.sv
// Multi-port writeback arbiter: grants up to NUM_WB_PORTS done units per cycle into
// registered packets. Define CVA5_WB_ROUND_ROBIN_EN for rotating priority; otherwise fixed.
module multi_port_writeback
  import cva5_types::*;
#(
  parameter int NUM_WB_UNITS = 5,
  parameter int NUM_WB_PORTS = 2,
  parameter int DATA_WIDTH   = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  multi_port_writeback_if.slave wb
);
  localparam int PTR_W = (NUM_WB_UNITS > 1) ? $clog2(NUM_WB_UNITS) : 1;

  logic [NUM_WB_UNITS-1:0]                   req;
  logic [NUM_WB_UNITS-1:0]                   ack;
  logic [NUM_WB_PORTS-1:0][NUM_WB_UNITS-1:0] grant;
  logic [PTR_W-1:0]                          ptr_cur;
  wb_packet_t [NUM_WB_PORTS-1:0]             pkt_d, pkt_q;

  // Masking requests during reset suppresses both the acks and any grant that cycle.
  assign req = wb.unit_done & {NUM_WB_UNITS{rst_n}};

`ifdef CVA5_WB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] last_idx;

  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= '0;
    else if (|ack)
      ptr <= (last_idx == PTR_W'(NUM_WB_UNITS-1)) ? '0 : last_idx + PTR_W'(1);
  end

  assign ptr_cur = ptr;
`else
  assign ptr_cur = '0;
`endif

  rr_multi_grant #(
    .N (NUM_WB_UNITS),
    .P (NUM_WB_PORTS)
  ) u_grant (
    .req      (req),
    .ptr      (ptr_cur),
    .grant    (grant),
`ifdef CVA5_WB_ROUND_ROBIN_EN
    .last_idx (last_idx)
`else
    .last_idx ()
`endif
  );

  always_comb begin
    ack = '0;
    for (int p = 0; p < NUM_WB_PORTS; p++) ack |= grant[p];
  end

  assign wb.unit_ack = ack;

  // Idle ports keep their last id/data so only valid toggles.
  always_comb begin
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      pkt_d[p]       = pkt_q[p];
      pkt_d[p].valid = 1'b0;
      for (int i = 0; i < NUM_WB_UNITS; i++) begin
        if (grant[p][i]) begin
          pkt_d[p].valid = 1'b1;
          pkt_d[p].id    = wb.unit_id[i];
          pkt_d[p].data  = XLEN'(wb.unit_rd[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) pkt_q <= '0;
    else        pkt_q <= pkt_d;
  end

  assign wb.wb_packet = pkt_q;
endmodule

// File: tb/tb_multi_port_writeback.sv
// Directed bench for multi_port_writeback; expectations follow the build selected by
// CVA5_WB_ROUND_ROBIN_EN (fixed priority when undefined).
module tb_multi_port_writeback;
  import cva5_types::*;

  localparam int NU = 5;
  localparam int NP = 2;
  localparam int DW = 32;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  multi_port_writeback_if #(.NUM_WB_UNITS(NU), .NUM_WB_PORTS(NP), .DATA_WIDTH(DW)) wb ();

  multi_port_writeback #(
    .NUM_WB_UNITS (NU),
    .NUM_WB_PORTS (NP),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  id_t         id_tab [NU];
  logic [31:0] d_tab  [NU];

  function automatic wb_packet_t pk(input logic v, input id_t id, input logic [31:0] d);
    wb_packet_t r;
    r.valid = v;
    r.id    = id;
    r.data  = d;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive done vector mid-cycle, check the combinational ack, then step past the edge.
  task automatic cycle(input string tag, input logic [NU-1:0] done, input logic [NU-1:0] exp_ack);
    @(negedge clk);
    wb.unit_done = done;
    #1;
    check({tag, "_ack"}, 64'(wb.unit_ack), 64'(exp_ack));
    @(posedge clk);
    #1;
  endtask

  task automatic check_ports(input string tag, input wb_packet_t e0, input wb_packet_t e1);
    check({tag, "_p0"}, 64'(wb.wb_packet[0]), 64'(e0));
    check({tag, "_p1"}, 64'(wb.wb_packet[1]), 64'(e1));
  endtask

  initial begin
    id_tab = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd7};
    d_tab  = '{32'hDEAD_0000, 32'hBEEF_0001, 32'hCAFE_0002, 32'h1234_0003, 32'h5678_0004};
    for (int i = 0; i < NU; i++) begin
      wb.unit_id[i] = id_tab[i];
      wb.unit_rd[i] = d_tab[i];
    end

    // Reset held two cycles with every unit done: no acks, cleared ports.
    rst_n        = 1'b0;
    wb.unit_done = 5'b11111;
    #1;
    check("rst_ack", 64'(wb.unit_ack), 64'(5'b00000));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_ack2", 64'(wb.unit_ack), 64'(5'b00000));
    check_ports("rst", pk(1'b0, 4'd0, 32'd0), pk(1'b0, 4'd0, 32'd0));

    // Release: arbitration starts from unit 0.
    @(negedge clk);
    rst_n = 1'b1;
    cycle("rel", 5'b11111, 5'b00011);
    check_ports("rel", pk(1'b1, 4'd1, d_tab[0]), pk(1'b1, 4'd2, d_tab[1]));

`ifdef CVA5_WB_ROUND_ROBIN_EN
    cycle("full2", 5'b11111, 5'b01100);
    check_ports("full2", pk(1'b1, 4'd3, d_tab[2]), pk(1'b1, 4'd5, d_tab[3]));
    cycle("full3", 5'b11111, 5'b10001);
    check_ports("full3", pk(1'b1, 4'd7, d_tab[4]), pk(1'b1, 4'd1, d_tab[0]));
`else
    cycle("full2", 5'b11111, 5'b00011);
    check_ports("full2", pk(1'b1, 4'd1, d_tab[0]), pk(1'b1, 4'd2, d_tab[1]));
    cycle("full3", 5'b11111, 5'b00011);
    check_ports("full3", pk(1'b1, 4'd1, d_tab[0]), pk(1'b1, 4'd2, d_tab[1]));
`endif

    // Underload: both done units acked in one cycle, lower index on port 0.
    cycle("under", 5'b10100, 5'b10100);
    check_ports("under", pk(1'b1, 4'd3, d_tab[2]), pk(1'b1, 4'd7, d_tab[4]));

    // Idle: valid drops, id/data hold.
    cycle("idle", 5'b00000, 5'b00000);
    check_ports("idle", pk(1'b0, 4'd3, d_tab[2]), pk(1'b0, 4'd7, d_tab[4]));

    // Single request lands on port 0 only.
    cycle("single", 5'b01000, 5'b01000);
    check_ports("single", pk(1'b1, 4'd5, d_tab[3]), pk(1'b0, 4'd7, d_tab[4]));

    // Units 0 and 4 together; with rotation the scan wraps 4 -> 0.
    cycle("wrap", 5'b10001, 5'b10001);
`ifdef CVA5_WB_ROUND_ROBIN_EN
    check_ports("wrap", pk(1'b1, 4'd7, d_tab[4]), pk(1'b1, 4'd1, d_tab[0]));
`else
    check_ports("wrap", pk(1'b1, 4'd1, d_tab[0]), pk(1'b1, 4'd7, d_tab[4]));
`endif

    // Port carries the id/data present in the grant cycle.
    @(negedge clk);
    wb.unit_id[1] = 4'd9;
    wb.unit_rd[1] = 32'h0BAD_F00D;
    cycle("fresh", 5'b00010, 5'b00010);
`ifdef CVA5_WB_ROUND_ROBIN_EN
    check_ports("fresh", pk(1'b1, 4'd9, 32'h0BAD_F00D), pk(1'b0, 4'd1, d_tab[0]));
`else
    check_ports("fresh", pk(1'b1, 4'd9, 32'h0BAD_F00D), pk(1'b0, 4'd7, d_tab[4]));
`endif

    // Reset mid-operation discards the grant of that cycle.
    @(negedge clk);
    rst_n = 1'b0;
    cycle("midrst", 5'b00110, 5'b00000);
    check_ports("midrst", pk(1'b0, 4'd0, 32'd0), pk(1'b0, 4'd0, 32'd0));

    // First post-reset cycle arbitrates from unit 0.
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post", 5'b11000, 5'b11000);
    check_ports("post", pk(1'b1, 4'd5, d_tab[3]), pk(1'b1, 4'd7, d_tab[4]));

    // Last grant was unit 4, so rotation also restarts at unit 0.
    cycle("after", 5'b11111, 5'b00011);
    check_ports("after", pk(1'b1, 4'd1, d_tab[0]), pk(1'b1, 4'd9, 32'h0BAD_F00D));

    wb.unit_done = 5'b00000;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multi_port_writeback.md
MULTI_PORT_WRITEBACK -- requirements
Module: multi_port_writeback

Interface
REQ-001 Parameter NUM_WB_UNITS, default 5, number of writeback-producing units (1..8).
REQ-002 Parameter NUM_WB_PORTS, default 2, number of register-file writeback ports (1..NUM_WB_UNITS).
REQ-003 Parameter DATA_WIDTH, default 32, result width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 unit_id  input  NUM_WB_UNITS x id_t  instruction id per unit.
REQ-007 unit_done  input  NUM_WB_UNITS  unit holds a completed result.
REQ-008 unit_rd  input  NUM_WB_UNITS x DATA_WIDTH  result data per unit.
REQ-009 unit_ack  output  NUM_WB_UNITS  result accepted this cycle; unit drops or advances next cycle.
REQ-010 wb_packet  output  NUM_WB_PORTS x wb_packet_t  registered {valid, id, data} per port.

Function
REQ-011 Each cycle, the block SHALL grant min(popcount(unit_done), NUM_WB_PORTS) units; no unit granted twice.
REQ-012 unit_ack[i] SHALL be combinational, asserted the same cycle unit i is granted, never without unit_done[i].
REQ-013 Granted units SHALL map to ports in grant order: first grant -> port 0, second -> port 1, etc.; unused ports valid=0.
REQ-014 wb_packet SHALL be registered: a grant in cycle N appears on the port in cycle N+1 with that unit's cycle-N id and data; latency exactly 1.
REQ-015 wb_packet[p].valid SHALL be 1 for exactly one cycle per grant; id/data of invalid ports SHALL hold the previous value (no toggling).
REQ-016 Grant search SHALL start at priority pointer ptr (log2 NUM_WB_UNITS bits) and wrap from NUM_WB_UNITS-1 to 0.
REQ-017 After any cycle with >=1 grant, ptr SHALL become (last granted index + 1) mod NUM_WB_UNITS; with no grant ptr SHALL hold.
REQ-018 Non-power-of-two NUM_WB_UNITS: ptr SHALL never exceed NUM_WB_UNITS-1.
REQ-019 popcount(unit_done) <= NUM_WB_PORTS: all done units SHALL be acked in that cycle regardless of ptr.
REQ-020 Ungranted done units SHALL receive no ack and must be re-presented; the block holds no per-unit buffering.
REQ-021 Every unit continuously done SHALL be granted within ceil(NUM_WB_UNITS/NUM_WB_PORTS) cycles (round-robin build).

Reset
REQ-022 While rst_n=0: all wb_packet valid=0, id/data=0, ptr=0, unit_ack=0 regardless of unit_done.
REQ-023 Reset mid-operation SHALL discard any grant of that cycle; the first post-reset cycle arbitrates from ptr=0.

Configuration
REQ-024 Macro CVA5_WB_ROUND_ROBIN_EN defined: pointer-based rotating priority per REQ-016/017/021.
REQ-025 Macro undefined: fixed priority, lowest index first; ptr register not instantiated; REQ-021 waived; all other requirements hold.

Structure
REQ-026 id_t, wb_packet_t, MAX_NUM_UNITS SHALL live in cva5_types/cva5_config; no new package types.
REQ-027 One sub-module rr_multi_grant (inputs: request vector, ptr; outputs: up to NUM_WB_PORTS one-hot grants, last-grant index), instantiated once.
REQ-028 Output registers SHALL be the only datapath state; ptr the only control state.

Verification
REQ-029 Reset: rst_n=0 two cycles, unit_done=5'b11111 -> unit_ack=0, all valid=0; release -> first acks 5'b00011 (ptr=0, 2 ports).
REQ-030 Underload: unit_done=5'b10100, ids 3 and 7 on units 2 and 4 -> ack=5'b10100; next cycle port0={1,3,..}, port1={1,7,..}.
REQ-031 Fairness: unit_done=5'b11111 held 3 cycles (RR build) -> acks 00011, 01100, 10001; ptr 2, 4, 1.
REQ-032 Wrap: ptr=4, unit_done=5'b10001 -> port0 from unit 4, port1 from unit 0; ptr becomes 1.
REQ-033 Fixed-priority build: unit_done=5'b11111 held 3 cycles -> acks 00011 each cycle; units 2-4 never acked.
REQ-034 Mid-operation reset: grant at cycle N with rst_n=0 at N -> ack=0 at N, valid=0 at N+1, ptr=0.
